if_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the fetch PC, drives a request/acknowledge port to instruction memory, buffers fetched words while decode is stalled, and presents one instruction plus its PC per cycle to decode. Taken branches resolved downstream redirect it.

---
 rtl/if_fetch_if.sv | 29 ++
 rtl/if_fetch.sv | 163 ++++++++++++++++
 tb/tb_if_fetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction memory request/acknowledge port
// Signals:
//   imem_req_o   fetch request, held with imem_addr_o until acknowledged
//   imem_addr_o  fetch word address
//   imem_ack_i   request accepted; imem_data_i valid in the same cycle
//   imem_data_i  fetched instruction word
// Modports: master (fetch stage side), slave (memory side).
interface if_fetch_if #(
  parameter int W_PC = 16
);
  logic            imem_req_o;
  logic [W_PC-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [31:0]     imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with prefetch buffer and branch redirect
// Build option: define IF_PREFETCH_EN for a two-entry prefetch buffer (one entry otherwise).
// Ports:
//   clk                      clock
//   rst                      asynchronous active-low reset
//   stall_i                  decode stalled; inst_o/pc_value_o hold
//   br_taken_i, br_target_i  taken branch; redirect fetch to br_target_i
//   imem                     instruction memory port (if_fetch_if.master)
//   inst_o, pc_value_o       instruction and its PC presented to decode
module if_fetch #(
  parameter int              W_PC     = 16,
  parameter logic [W_PC-1:0] RESET_PC = 16'h0000,
  parameter logic [31:0]     NOP_INST = 32'h3C00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [W_PC-1:0]   br_target_i,
  if_fetch_if.master        imem,
  output logic [31:0]       inst_o,
  output logic [W_PC-1:0]   pc_value_o
);

`ifdef IF_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W_PC-1:0]   pc_q, pc_d;
  logic [W_PC-1:0]   drain_addr_q, drain_addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       buf_inst_q [D];
  logic [31:0]       buf_inst_d [D];
  logic [W_PC-1:0]   buf_pc_q [D];
  logic [W_PC-1:0]   buf_pc_d [D];
  logic [31:0]       inst_q, inst_d;
  logic [W_PC-1:0]   pcv_q, pcv_d;

  logic              req;
  logic              fire;
  logic              fetch_fire;
  logic              pop;
  logic              bypass;
  logic              push;
  logic [CW-1:0]     wr_idx;

  // Request comes straight from the state register; gating with rst keeps it
  // low while reset is held and lets it rise in the first cycle after release.
  assign req              = (state_q != S_FULL);
  assign imem.imem_req_o  = req && rst;
  // While draining, the abandoned request must stay stable at its old address.
  assign imem.imem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign inst_o     = inst_q;
  assign pc_value_o = pcv_q;

  assign fire       = req && imem.imem_ack_i;
  assign fetch_fire = fire && (state_q == S_FETCH);
  assign pop        = !stall_i && (cnt_q != '0);
  assign bypass     = !stall_i && (cnt_q == '0) && fetch_fire;
  assign push       = fetch_fire && !bypass;
  // A pop on the same edge shifts the queue down, so the push lands one lower.
  assign wr_idx     = cnt_q - CW'(pop);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    cnt_d        = cnt_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_d       = inst_q;
    pcv_d        = pcv_q;

    if (br_taken_i) begin
      // Redirect beats stall and ack: everything fetched so far is wrong-path.
      cnt_d  = '0;
      inst_d = NOP_INST;
      pcv_d  = '0;
      pc_d   = br_target_i;
      if (req && !imem.imem_ack_i) begin
        state_d = S_DRAIN;
        // A second branch while draining only replaces the target in pc_q.
        if (state_q != S_DRAIN) drain_addr_d = pc_q;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      if (fetch_fire) pc_d = pc_q + W_PC'(1);

      if (!stall_i) begin
        if (pop) begin
          inst_d = buf_inst_q[0];
          pcv_d  = buf_pc_q[0];
        end else if (bypass) begin
          inst_d = imem.imem_data_i;
          pcv_d  = pc_q;
        end else begin
          inst_d = NOP_INST;
          pcv_d  = '0;
        end
      end

      if (pop) begin
        for (int i = 0; i < D - 1; i++) begin
          buf_inst_d[i] = buf_inst_q[i + 1];
          buf_pc_d[i]   = buf_pc_q[i + 1];
        end
      end
      for (int i = 0; i < D; i++) begin
        if (push && (CW'(i) == wr_idx)) begin
          buf_inst_d[i] = imem.imem_data_i;
          buf_pc_d[i]   = pc_q;
        end
      end
      cnt_d = cnt_q - CW'(pop) + CW'(push);

      case (state_q)
        S_FETCH: if (fetch_fire && (cnt_d == CW'(D))) state_d = S_FULL;
        S_FULL:  if (pop) state_d = S_FETCH;
        S_DRAIN: if (fire) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      cnt_q        <= '0;
      inst_q       <= NOP_INST;
      pcv_q        <= '0;
      for (int i = 0; i < D; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      pcv_q        <= pcv_d;
      for (int i = 0; i < D; i++) begin
        buf_inst_q[i] <= buf_inst_d[i];
        buf_pc_q[i]   <= buf_pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h3C00_0000;
`ifdef IF_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [15:0] br_target_i = 16'h0;
  logic [31:0] inst_o, inst2;
  logic [15:0] pc_value_o, pc2;

  if_fetch_if m_if ();
  if_fetch_if m2 ();

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .imem(m_if), .inst_o(inst_o), .pc_value_o(pc_value_o)
  );

  if_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .stall_i(1'b0), .br_taken_i(1'b0),
    .br_target_i(16'h0), .imem(m2), .inst_o(inst2), .pc_value_o(pc2)
  );

  assign m2.imem_ack_i  = 1'b1;
  assign m2.imem_data_i = 32'h1000_0000 + {16'h0, m2.imem_addr_o};

  int          checks = 0;
  int          errors = 0;
  int          mem_wait = 0;
  int          wcnt = 0;
  logic        out_pend = 1'b0;
  logic [15:0] pend_addr = 16'h0;
  logic [15:0] next_pc = 16'h0;
  logic [47:0] q[$];
  logic [31:0] exp_inst = NOP;
  logic [15:0] exp_pc = 16'h0;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic [31:0] inst;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                              input logic r, input logic [15:0] a,
                              input logic [31:0] w, input logic [15:0] p);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.req = r; v.addr = a; v.inst = w; v.pc = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic sb_reset();
    q.delete();
    next_pc  = 16'h0;
    exp_inst = NOP;
    exp_pc   = 16'h0;
    out_pend = 1'b0;
    wcnt     = 0;
  endtask

  // One clock cycle: memory responds, scoreboard records what the edge should
  // deliver, then outputs are compared half a cycle after the edge.
  task automatic tick();
    logic was_stall, was_br;
    if (out_pend) begin
      chk("req_held", 48'(m_if.imem_req_o), 48'(1));
      chk("addr_held", 48'(m_if.imem_addr_o), 48'(pend_addr));
    end
    if (m_if.imem_req_o) begin
      if (wcnt >= mem_wait) begin m_if.imem_ack_i = 1'b1; wcnt = 0; end
      else begin m_if.imem_ack_i = 1'b0; wcnt++; end
    end else begin
      m_if.imem_ack_i = (mem_wait == 0);
      wcnt = 0;
    end
    m_if.imem_data_i = 32'h1000_0000 + {16'h0, m_if.imem_addr_o};
    out_pend  = m_if.imem_req_o && !m_if.imem_ack_i;
    pend_addr = m_if.imem_addr_o;
    if (br_taken_i) begin
      q.delete();
      next_pc = br_target_i;
    end else if (m_if.imem_req_o && m_if.imem_ack_i && (m_if.imem_addr_o == next_pc)) begin
      q.push_back({m_if.imem_data_i, m_if.imem_addr_o});
      next_pc = next_pc + 16'd1;
    end
    was_stall = stall_i;
    was_br    = br_taken_i;
    @(posedge clk);
    @(negedge clk);
    if (was_br) begin
      exp_inst = NOP; exp_pc = 16'h0;
    end else if (!was_stall) begin
      if (q.size() > 0) begin
        {exp_inst, exp_pc} = q.pop_front();
      end else begin
        exp_inst = NOP; exp_pc = 16'h0;
      end
    end
    chk("sb_out", {inst_o, pc_value_o}, {exp_inst, exp_pc});
  endtask

  initial begin
    logic        seen5, seen40, first_checked, found;
    logic [15:0] a2;

    tbl[0]  = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 32'h1000_0000, 16'h0000);
    tbl[1]  = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0001, 32'h1000_0001, 16'h0001);
    tbl[2]  = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0002, 32'h1000_0002, 16'h0002);
    tbl[3]  = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 32'h1000_0003, 16'h0003);
    tbl[4]  = mk(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0004, NOP, 16'h0000);
    tbl[5]  = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0010, 32'h1000_0010, 16'h0010);
    tbl[6]  = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0011, 32'h1000_0011, 16'h0011);
    tbl[7]  = mk(1'b1, 1'b0, 16'h0, 1'b1, 16'h0012, 32'h1000_0011, 16'h0011);
    tbl[8]  = mk(1'b1, 1'b0, 16'h0, (D == 2), 16'h0013, 32'h1000_0011, 16'h0011);
    tbl[9]  = mk(1'b1, 1'b0, 16'h0, 1'b0, 16'h0012 + 16'(D), 32'h1000_0011, 16'h0011);
    tbl[10] = mk(1'b1, 1'b0, 16'h0, 1'b0, 16'h0012 + 16'(D), 32'h1000_0011, 16'h0011);
    tbl[11] = mk(1'b1, 1'b0, 16'h0, 1'b0, 16'h0012 + 16'(D), 32'h1000_0011, 16'h0011);
    tbl[12] = mk(1'b0, 1'b0, 16'h0, 1'b0, 16'h0012 + 16'(D), 32'h1000_0012, 16'h0012);
    tbl[13] = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0012 + 16'(D), 32'h1000_0013, 16'h0013);
    tbl[14] = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0013 + 16'(D), 32'h1000_0014, 16'h0014);
    tbl[15] = mk(1'b0, 1'b0, 16'h0, 1'b1, 16'h0014 + 16'(D), 32'h1000_0015, 16'h0015);

    m_if.imem_ack_i  = 1'b0;
    m_if.imem_data_i = 32'h0;

    // Reset values while rst is held
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 48'(m_if.imem_req_o), 48'(0));
    chk("rst_addr", 48'(m_if.imem_addr_o), 48'(16'h0000));
    chk("rst_inst", 48'(inst_o), 48'(NOP));
    chk("rst_pc", 48'(pc_value_o), 48'(0));
    chk("rst_addr2", 48'(m2.imem_addr_o), 48'(16'hFFFE));
    rst = 1'b1;
    sb_reset();
    #1;

    // Zero-wait table: streaming, redirect, 5-cycle stall, release
    for (int i = 0; i < 16; i++) begin
      stall_i     = tbl[i].stall;
      br_taken_i  = tbl[i].br;
      br_target_i = tbl[i].tgt;
      chk($sformatf("tbl%0d_req", i), 48'(m_if.imem_req_o), 48'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), 48'(m_if.imem_addr_o), 48'(tbl[i].addr));
      a2 = 16'hFFFE + 16'(i);
      if (i < 4) chk($sformatf("wrap%0d_addr", i), 48'(m2.imem_addr_o), 48'(a2));
      tick();
      chk($sformatf("tbl%0d_inst", i), 48'(inst_o), 48'(tbl[i].inst));
      chk($sformatf("tbl%0d_pc", i), 48'(pc_value_o), 48'(tbl[i].pc));
      if (i < 4) chk($sformatf("wrap%0d_out", i), {inst2, pc2}, {32'h1000_0000 + {16'h0, a2}, a2});
    end
    stall_i    = 1'b0;
    br_taken_i = 1'b0;

    // Three-cycle ack latency, restarting from address 2
    mem_wait    = 3;
    br_taken_i  = 1'b1;
    br_target_i = 16'h0002;
    tick();
    br_taken_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      if (m_if.imem_req_o && m_if.imem_addr_o == 16'h0005 && wcnt == 1) found = 1'b1;
      else tick();
    end
    chk("reach_req5", 48'(found), 48'(1));

    // Redirect to 0x0040 while 0x0005 is outstanding (ack two cycles later)
    br_taken_i  = 1'b1;
    br_target_i = 16'h0040;
    tick();
    br_taken_i = 1'b0;
    seen5 = 1'b0; seen40 = 1'b0; first_checked = 1'b0;
    for (int n = 0; n < 40 && !seen40; n++) begin
      if (!first_checked && m_if.imem_req_o && m_if.imem_addr_o != 16'h0005) begin
        chk("redirect_addr", 48'(m_if.imem_addr_o), 48'(16'h0040));
        first_checked = 1'b1;
      end
      tick();
      if (pc_value_o == 16'h0005 && inst_o != NOP) seen5 = 1'b1;
      if (pc_value_o == 16'h0040) seen40 = 1'b1;
    end
    chk("no_stale_pc5", 48'(seen5), 48'(0));
    chk("target_pc40_seen", 48'(seen40), 48'(1));
    chk("redirect_checked", 48'(first_checked), 48'(1));

    // Reset during a stall with a full buffer
    mem_wait = 0;
    wcnt     = 0;
    for (int n = 0; n < 3; n++) tick();
    stall_i = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("full_req", 48'(m_if.imem_req_o), 48'(0));
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 48'(m_if.imem_req_o), 48'(0));
    chk("mid_rst_addr", 48'(m_if.imem_addr_o), 48'(16'h0000));
    chk("mid_rst_inst", 48'(inst_o), 48'(NOP));
    chk("mid_rst_pc", 48'(pc_value_o), 48'(0));
    stall_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb_reset();
    #1;
    chk("post_rst_req", 48'(m_if.imem_req_o), 48'(1));
    chk("post_rst_addr", 48'(m_if.imem_addr_o), 48'(16'h0000));
    for (int n = 0; n < 6; n++) tick();
    chk("post_rst_pc", 48'(pc_value_o), 48'(16'h0005));
    chk("sb_empty", 48'(q.size()), 48'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
